// File: rtl/test_seq_pkg.sv
// Shared definitions for the test sequencer: FSM state encoding, scenario ids
// and the address/data constants used by the scenario table.
package test_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [4:0] SCN_M0_WR_LO    = 5'd1;
    localparam logic [4:0] SCN_M0_RD_LO    = 5'd2;
    localparam logic [4:0] SCN_M0_WR_MID   = 5'd3;
    localparam logic [4:0] SCN_M0_RD_MID   = 5'd4;
    localparam logic [4:0] SCN_M1_WR_HI    = 5'd5;
    localparam logic [4:0] SCN_M1_RD_HI    = 5'd6;
    localparam logic [4:0] SCN_DUAL_WR     = 5'd7;
    localparam logic [4:0] SCN_DUAL_RD     = 5'd8;
    localparam logic [4:0] SCN_M0_BURST_WR = 5'd9;
    localparam logic [4:0] SCN_M1_BURST_RD = 5'd10;
    localparam logic [4:0] SCN_MAX_ID      = 5'd10;

    // Table constants are kept 32 bits wide and fitted to the port widths at use.
    localparam logic [31:0] ADDR_LO       = 32'd1001;
    localparam logic [31:0] ADDR_MID      = 32'd5097;
    localparam logic [31:0] ADDR_MID_NEXT = 32'd5098;
    localparam logic [31:0] ADDR_HI       = 32'd9193;
    localparam logic [31:0] DATA_A        = 32'd101;
    localparam logic [31:0] DATA_B        = 32'd102;
    localparam logic [31:0] DATA_C        = 32'd103;
    localparam logic [31:0] BURST_INCR    = 32'd1;

    function automatic logic scenario_valid(input logic [4:0] id);
        return (id != 5'd0) && (id <= SCN_MAX_ID);
    endfunction

endpackage

// File: rtl/scenario_rom.sv
// Combinational scenario table: maps a scenario id onto the per-master
// enable/read/burst/data/address vectors. Masters above 1 are always idle.
module scenario_rom
    import test_seq_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 3
) (
    input  logic [4:0]                         id,
    output logic                               valid,
    output logic [NUM_MASTERS-1:0]             enable,
    output logic [NUM_MASTERS-1:0]             read_en,
    output logic [NUM_MASTERS*BURST_WIDTH-1:0] burst_mode,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]  data,
    output logic [NUM_MASTERS*ADDR_WIDTH-1:0]  addr
);

    logic                   en0, en1, rd0, rd1;
    logic [BURST_WIDTH-1:0] b0, b1;
    logic [DATA_WIDTH-1:0]  d0, d1;
    logic [ADDR_WIDTH-1:0]  a0, a1;

    always_comb begin
        valid = scenario_valid(id);
        en0 = 1'b0;
        en1 = 1'b0;
        rd0 = 1'b0;
        rd1 = 1'b0;
        b0  = '0;
        b1  = '0;
        d0  = '0;
        d1  = '0;
        a0  = '0;
        a1  = '0;
        case (id)
            SCN_M0_WR_LO: begin
                en0 = 1'b1;
                d0  = DATA_WIDTH'(DATA_A);
                a0  = ADDR_WIDTH'(ADDR_LO);
            end
            SCN_M0_RD_LO: begin
                en0 = 1'b1;
                rd0 = 1'b1;
                a0  = ADDR_WIDTH'(ADDR_LO);
            end
            SCN_M0_WR_MID: begin
                en0 = 1'b1;
                d0  = DATA_WIDTH'(DATA_A);
                a0  = ADDR_WIDTH'(ADDR_MID);
            end
            SCN_M0_RD_MID: begin
                en0 = 1'b1;
                rd0 = 1'b1;
                a0  = ADDR_WIDTH'(ADDR_MID);
            end
            SCN_M1_WR_HI: begin
                en1 = 1'b1;
                d1  = DATA_WIDTH'(DATA_A);
                a1  = ADDR_WIDTH'(ADDR_HI);
            end
            SCN_M1_RD_HI: begin
                en1 = 1'b1;
                rd1 = 1'b1;
                a1  = ADDR_WIDTH'(ADDR_HI);
            end
            SCN_DUAL_WR: begin
                en0 = 1'b1;
                en1 = 1'b1;
                d0  = DATA_WIDTH'(DATA_B);
                d1  = DATA_WIDTH'(DATA_C);
                a0  = ADDR_WIDTH'(ADDR_MID);
                a1  = ADDR_WIDTH'(ADDR_MID_NEXT);
            end
            SCN_DUAL_RD: begin
                en0 = 1'b1;
                en1 = 1'b1;
                rd0 = 1'b1;
                rd1 = 1'b1;
                a0  = ADDR_WIDTH'(ADDR_MID_NEXT);
                a1  = ADDR_WIDTH'(ADDR_MID);
            end
            SCN_M0_BURST_WR: begin
                en0 = 1'b1;
                b0  = BURST_WIDTH'(BURST_INCR);
                d0  = DATA_WIDTH'(DATA_A);
                a0  = ADDR_WIDTH'(ADDR_LO);
            end
            SCN_M1_BURST_RD: begin
                en1 = 1'b1;
                rd1 = 1'b1;
                b1  = BURST_WIDTH'(BURST_INCR);
                a1  = ADDR_WIDTH'(ADDR_LO);
            end
            default: ;
        endcase
    end

    always_comb begin
        enable     = '0;
        read_en    = '0;
        burst_mode = '0;
        data       = '0;
        addr       = '0;
        enable[0]  = en0;
        enable[1]  = en1;
        read_en[0] = rd0;
        read_en[1] = rd1;
        burst_mode[0 +: BURST_WIDTH]           = b0;
        burst_mode[BURST_WIDTH +: BURST_WIDTH] = b1;
        data[0 +: DATA_WIDTH]                  = d0;
        data[DATA_WIDTH +: DATA_WIDTH]         = d1;
        addr[0 +: ADDR_WIDTH]                  = a0;
        addr[ADDR_WIDTH +: ADDR_WIDTH]         = a1;
    end

endmodule

// File: rtl/test_sequencer.sv
// Scenario-driven bus-master stimulus sequencer: issues a table scenario to the
// masters, waits for their requests to drop, and reports done or error.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 8,
    parameter int BURST_WIDTH    = 3,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [4:0]                         scenario_id,
    input  logic [NUM_MASTERS-1:0]             m_request,
    output logic [NUM_MASTERS-1:0]             m_enable,
    output logic [NUM_MASTERS-1:0]             m_read_en,
    output logic [NUM_MASTERS*BURST_WIDTH-1:0] m_burst_mode,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_data,
    output logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    output logic [4:0]                         state_out,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    seq_state_t  state;
    logic [7:0]  hold_cnt;
    logic [15:0] wait_cnt;

    logic                               rom_valid;
    logic [NUM_MASTERS-1:0]             rom_enable;
    logic [NUM_MASTERS-1:0]             rom_read_en;
    logic [NUM_MASTERS*BURST_WIDTH-1:0] rom_burst;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]  rom_data;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]  rom_addr;

    scenario_rom #(
        .NUM_MASTERS (NUM_MASTERS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_rom (
        .id         (scenario_id),
        .valid      (rom_valid),
        .enable     (rom_enable),
        .read_en    (rom_read_en),
        .burst_mode (rom_burst),
        .data       (rom_data),
        .addr       (rom_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            wait_cnt     <= '0;
            m_enable     <= '0;
            m_read_en    <= '0;
            m_burst_mode <= '0;
            m_data       <= '0;
            m_addr       <= '0;
            state_out    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy      <= 1'b0;
                    state_out <= '0;
                    if (start) begin
                        if (rom_valid) begin
                            state        <= ST_ISSUE;
                            state_out    <= scenario_id;
                            busy         <= 1'b1;
                            hold_cnt     <= '0;
                            m_enable     <= rom_enable;
                            m_read_en    <= rom_read_en;
                            m_burst_mode <= rom_burst;
                            m_data       <= rom_data;
                            m_addr       <= rom_addr;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_WAIT;
                        m_enable <= '0;
                        wait_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                // Completion is tested first so it wins over a coincident timeout.
                ST_WAIT: begin
                    if (m_request == '0) begin
                        state        <= ST_DONE;
                        done         <= 1'b1;
                        m_read_en    <= '0;
                        m_burst_mode <= '0;
                        m_data       <= '0;
                        m_addr       <= '0;
                    end else if (wait_cnt == TO_LAST) begin
                        state        <= ST_IDLE;
                        error        <= 1'b1;
                        busy         <= 1'b0;
                        state_out    <= '0;
                        m_read_en    <= '0;
                        m_burst_mode <= '0;
                        m_data       <= '0;
                        m_addr       <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    state_out <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: directed scenarios push expected events,
// a negedge monitor pops and compares whenever the DUT shows issue/done/error.
module tb_test_sequencer;

    localparam int NM  = 4;
    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int BW  = 3;
    localparam int HC  = 3;
    localparam int TOC = 16;

    localparam int K_ISSUE = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int              kind;
        logic [4:0]      sid;
        logic [NM-1:0]   en;
        logic [NM-1:0]   rd;
        logic [NM*BW-1:0] burst;
        logic [NM*DW-1:0] data;
        logic [NM*AW-1:0] addr;
        int              lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [4:0]       scenario_id;
    logic [NM-1:0]    m_request;
    logic [NM-1:0]    m_enable;
    logic [NM-1:0]    m_read_en;
    logic [NM*BW-1:0] m_burst_mode;
    logic [NM*DW-1:0] m_data;
    logic [NM*AW-1:0] m_addr;
    logic [4:0]       state_out;
    logic             busy;
    logic             done;
    logic             error;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    test_sequencer #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BURST_WIDTH    (BW),
        .HOLD_CYCLES    (HC),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .scenario_id  (scenario_id),
        .m_request    (m_request),
        .m_enable     (m_enable),
        .m_read_en    (m_read_en),
        .m_burst_mode (m_burst_mode),
        .m_data       (m_data),
        .m_addr       (m_addr),
        .state_out    (state_out),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_master_fields();
        return 64'({m_enable, m_read_en, m_burst_mode, m_data}) | 64'(m_addr);
    endfunction

    function automatic exp_t mk(input int kind, input logic [4:0] sid,
                                input logic [1:0] en, input logic [1:0] rd,
                                input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input int lat);
        exp_t e;
        e.kind  = kind;
        e.sid   = sid;
        e.en    = NM'(en);
        e.rd    = NM'(rd);
        e.burst = '0;
        e.data  = '0;
        e.addr  = '0;
        e.burst[0 +: BW]  = b0;
        e.burst[BW +: BW] = b1;
        e.data[0 +: DW]   = d0;
        e.data[DW +: DW]  = d1;
        e.addr[0 +: AW]   = a0;
        e.addr[AW +: AW]  = a1;
        e.lat   = lat;
        return e;
    endfunction

    function automatic exp_t ev(input int kind, input logic [4:0] sid, input int lat);
        return mk(kind, sid, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, lat);
    endfunction

    // Monitor: decoupled from stimulus, compares on every DUT-visible event.
    logic [NM-1:0] prev_en = '0;
    int            en_run = 0;
    int            wait_entry = 0;

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (!reset) begin
            prev_en = '0;
            en_run  = 0;
        end else begin
            kind = -1;
            if (m_enable != '0 && prev_en == '0) kind = K_ISSUE;
            else if (done) kind = K_DONE;
            else if (error) kind = K_ERR;
            if (m_enable != '0) en_run++;
            if (m_enable == '0 && prev_en != '0) begin
                chk("hold_cycles", 64'(en_run), 64'(HC));
                en_run = 0;
                wait_entry = cyc;
            end
            prev_en = m_enable;
            if (kind >= 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'(kind), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 64'(kind), 64'(e.kind));
                    if (kind == K_ISSUE) begin
                        chk("issue_enable", 64'(m_enable), 64'(e.en));
                        chk("issue_read_en", 64'(m_read_en), 64'(e.rd));
                        chk("issue_burst", 64'(m_burst_mode), 64'(e.burst));
                        chk("issue_data", 64'(m_data), 64'(e.data));
                        chk("issue_addr", 64'(m_addr), 64'(e.addr));
                        chk("issue_state_out", 64'(state_out), 64'(e.sid));
                        chk("issue_busy", 64'(busy), 64'd1);
                    end else begin
                        chk("end_outputs_zero", all_master_fields(), 64'd0);
                        chk("end_state_out", 64'(state_out), 64'(e.sid));
                        chk("end_busy", 64'(busy), (kind == K_DONE) ? 64'd1 : 64'd0);
                        if (e.lat >= 0)
                            chk("end_latency", 64'(cyc - wait_entry), 64'(e.lat));
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [4:0] id);
        scenario_id = id;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Full scenario: request raised in ISSUE, dropped 3 cycles into WAIT.
    task automatic run_ok(input logic [4:0] id, input logic [NM-1:0] req);
        launch(id);
        m_request = req;
        step(HC);
        step(3);
        m_request = '0;
        step(2);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        scenario_id = '0;
        m_request = '0;
        step(3);
        chk("reset_outputs", all_master_fields(), 64'd0);
        chk("reset_ctrl", 64'({state_out, busy, done, error}), 64'd0);
        reset = 1'b1;

        // Scenario 1: M0 write 101 @1001; starts on first edge after release.
        sb.push_back(mk(K_ISSUE, 5'd1, 2'b01, 2'b00, 3'd0, 3'd0, 8'd101, 8'd0, 14'd1001, 14'd0, -1));
        sb.push_back(ev(K_DONE, 5'd1, 4));
        run_ok(5'd1, 4'b0001);

        // Scenario 7: dual write.
        sb.push_back(mk(K_ISSUE, 5'd7, 2'b11, 2'b00, 3'd0, 3'd0, 8'd102, 8'd103, 14'd5097, 14'd5098, -1));
        sb.push_back(ev(K_DONE, 5'd7, 4));
        run_ok(5'd7, 4'b0011);

        // Scenarios 4 and 6: single-master reads.
        sb.push_back(mk(K_ISSUE, 5'd4, 2'b01, 2'b01, 3'd0, 3'd0, 8'd0, 8'd0, 14'd5097, 14'd0, -1));
        sb.push_back(ev(K_DONE, 5'd4, 4));
        run_ok(5'd4, 4'b0001);
        sb.push_back(mk(K_ISSUE, 5'd6, 2'b10, 2'b10, 3'd0, 3'd0, 8'd0, 8'd0, 14'd0, 14'd9193, -1));
        sb.push_back(ev(K_DONE, 5'd6, 4));
        run_ok(5'd6, 4'b0010);

        // Invalid ids raise error only.
        sb.push_back(ev(K_ERR, 5'd0, -1));
        launch(5'd0);
        step(1);
        chk("invalid0_busy", 64'(busy), 64'd0);
        sb.push_back(ev(K_ERR, 5'd0, -1));
        launch(5'd15);
        step(1);
        chk("invalid15_busy", 64'(busy), 64'd0);
        chk("invalid_outputs", all_master_fields(), 64'd0);

        // Scenario 5 with master1 request stuck: timeout 16 cycles after WAIT entry.
        sb.push_back(mk(K_ISSUE, 5'd5, 2'b10, 2'b00, 3'd0, 3'd0, 8'd0, 8'd101, 14'd0, 14'd9193, -1));
        sb.push_back(ev(K_ERR, 5'd0, TOC));
        launch(5'd5);
        m_request = 4'b0010;
        step(HC + TOC + 1);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_outputs", all_master_fields(), 64'd0);
        m_request = '0;
        step(1);

        // Scenario 10 cut by asynchronous reset in ISSUE cycle 2.
        sb.push_back(mk(K_ISSUE, 5'd10, 2'b10, 2'b10, 3'd0, 3'd1, 8'd0, 8'd0, 14'd0, 14'd1001, -1));
        launch(5'd10);
        m_request = 4'b0010;
        step(1);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_master_fields(), 64'd0);
        chk("async_reset_ctrl", 64'({state_out, busy, done, error}), 64'd0);
        m_request = '0;
        step(2);
        reset = 1'b1;
        sb.push_back(mk(K_ISSUE, 5'd9, 2'b01, 2'b00, 3'd1, 3'd0, 8'd101, 8'd0, 14'd1001, 14'd0, -1));
        sb.push_back(ev(K_DONE, 5'd9, 4));
        run_ok(5'd9, 4'b0001);

        // Scenario 8 on four masters, with a start/id change attempted mid-WAIT.
        sb.push_back(mk(K_ISSUE, 5'd8, 2'b11, 2'b11, 3'd0, 3'd0, 8'd0, 8'd0, 14'd5098, 14'd5097, -1));
        sb.push_back(ev(K_DONE, 5'd8, 4));
        launch(5'd8);
        m_request = 4'b0011;
        step(HC);
        scenario_id = 5'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        m_request = '0;
        step(2);
        chk("mid_wait_busy", 64'(busy), 64'd0);

        step(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter NUM_MASTERS, default 2; number of bus-master channels driven (min 2).
REQ-002 Parameter ADDR_WIDTH, default 14; per-master address width.
REQ-003 Parameter DATA_WIDTH, default 8; per-master write-data width.
REQ-004 Parameter BURST_WIDTH, default 3; per-master burst-mode code width.
REQ-005 Parameter HOLD_CYCLES, default 3; cycles enable is held in ISSUE (1..255).
REQ-006 Parameter TIMEOUT_CYCLES, default 1023; max WAIT cycles before abort (1..65535).
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  level; sampled in IDLE to launch a scenario.
REQ-010 scenario_id  input  5  scenario to run; valid 1..10.
REQ-011 m_request  input  NUM_MASTERS  per-master transaction-in-progress flag.
REQ-012 m_enable  output  NUM_MASTERS  per-master transaction enable.
REQ-013 m_read_en  output  NUM_MASTERS  per-master read(1)/write(0) select.
REQ-014 m_burst_mode  output  NUM_MASTERS*BURST_WIDTH  packed, master i at [i*BURST_WIDTH +: BURST_WIDTH].
REQ-015 m_data  output  NUM_MASTERS*DATA_WIDTH  packed write data, same packing rule.
REQ-016 m_addr  output  NUM_MASTERS*ADDR_WIDTH  packed address, same packing rule.
REQ-017 state_out  output  5  latched scenario_id while active, 0 in IDLE.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on normal completion.
REQ-020 error  output  1  one-cycle pulse on invalid scenario_id or timeout.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-022 IDLE: start=1 with valid id -> latch id, load scenario vectors, go ISSUE next cycle; start=1 with invalid id (0, 11..31) -> error pulse, remain IDLE.
REQ-023 ISSUE: m_enable = scenario mask for exactly HOLD_CYCLES cycles, then WAIT; hold counter zeroes on entry.
REQ-024 WAIT: m_enable all 0, read_en/burst/data/addr held; exit to DONE when m_request == 0.
REQ-025 WAIT: timeout counter increments each cycle; at TIMEOUT_CYCLES with any m_request high -> error pulse, clear all outputs, go IDLE; completion on same cycle wins over timeout.
REQ-026 DONE: done=1 one cycle, all per-master outputs cleared to 0, go IDLE.
REQ-027 start and scenario_id ignored outside IDLE; changes mid-run have no effect.
REQ-028 Scenario table, master0/master1 (masters >=2 always idle, zero fields):
  1: M0 write 101 @1001. 2: M0 read @1001. 3: M0 write 101 @5097. 4: M0 read @5097.
  5: M1 write 101 @9193. 6: M1 read @9193. 7: M0 write 102 @5097 + M1 write 103 @5098.
  8: M0 read @5098 + M1 read @5097. 9: M0 burst 1 write 101 @1001. 10: M1 burst 1 read @1001.
REQ-029 Unused masters in a scenario drive enable, read_en, burst, data, addr = 0; read scenarios drive data = 0.
REQ-030 Table constants truncate to DATA_WIDTH/ADDR_WIDTH LSBs when widths are narrower; zero-extend when wider.

Reset
REQ-031 reset=0 immediately forces IDLE, clears counters and drives every output to 0, including mid-ISSUE or mid-WAIT.
REQ-032 First scenario may start on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package test_seq_pkg holds state enum, scenario-id constants, max-id constant, and table address/data constants.
REQ-034 Sub-module scenario_rom: combinational id -> per-master enable/read/burst/data/addr vectors plus valid flag.

Verification
REQ-035 Reset, start=1 id=1, m_request 0 -> 1 during ISSUE -> 0 three cycles into WAIT -> m_enable=01 for 3 cycles, m_addr[13:0]=1001, m_data[7:0]=101, done pulse, busy 0.
REQ-036 id=7 -> both enables high 3 cycles; master0 data 102 @5097, master1 data 103 @5098; done after both requests low.
REQ-037 id=0 and id=15 with start=1 -> error pulse each, busy stays 0, outputs stay 0.
REQ-038 TIMEOUT_CYCLES=16, id=5, m_request[1] stuck 1 -> error pulse exactly 16 cycles after WAIT entry, outputs cleared, IDLE.
REQ-039 id=10 running, reset asserted during ISSUE cycle 2 -> all outputs 0 asynchronously, state_out 0; new start id=9 after release -> m_burst_mode master0 = 1.
REQ-040 NUM_MASTERS=4 build, id=8 -> masters 2,3 all fields 0; id change mid-WAIT ignored.
